alsu_ctrl: RTL and testbench

Round-robin request controller that shares one pipelined ALSU between two requesters. It accepts one operation at a time through a valid/ready handshake and drives the ALSU operand/opcode registers with a one-cycle load strobe. It then waits for the ALSU pipeline latency and returns the result, tagged with the requester ID, on a response channel that supports backpressure. The block sits between the requesting logic and the ALSU datapath. Only one operation is outstanding at any time.

---
 rtl/alsu_ctrl_if.sv | 50 +++++
 rtl/alsu_ctrl.sv | 132 +++++++++++++
 tb/tb_alsu_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_ctrl_if.sv
//----------------------------------------------------------------------
// alsu_ctrl_if -- requester, ALSU and response signals of alsu_ctrl. rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface alsu_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int OPW   = 3
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic [OPW-1:0]     req0_op;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic [OPW-1:0]     req1_op;
  logic [WIDTH-1:0]   alsu_a;
  logic [WIDTH-1:0]   alsu_b;
  logic [OPW-1:0]     alsu_opcode;
  logic               alsu_en;
  logic [2*WIDTH-1:0] alsu_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_data;
  logic               busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alsu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alsu_a, alsu_b, alsu_opcode, alsu_en,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alsu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alsu_a, alsu_b, alsu_opcode, alsu_en,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/alsu_ctrl.sv
//----------------------------------------------------------------------
// alsu_ctrl -- round-robin sharing of one pipelined ALSU between two requesters. rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module alsu_ctrl #(
  parameter int WIDTH = 3,
  parameter int OPW   = 3,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  alsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   alsu_a_q, alsu_a_d;
  logic [WIDTH-1:0]   alsu_b_q, alsu_b_d;
  logic [OPW-1:0]     alsu_op_q, alsu_op_d;
  logic               alsu_en_q, alsu_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               gnt;
  logic               rdy0;
  logic               rdy1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    alsu_a_d    = alsu_a_q;
    alsu_b_d    = alsu_b_q;
    alsu_op_d   = alsu_op_q;
    alsu_en_d   = alsu_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    // The pointer only matters under contention; a lone requester always wins.
    gnt  = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
    rdy0 = (state_q == IDLE) && bus.req0_valid && !gnt;
    rdy1 = (state_q == IDLE) && bus.req1_valid && gnt;

    case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          alsu_a_d  = gnt ? bus.req1_a  : bus.req0_a;
          alsu_b_d  = gnt ? bus.req1_b  : bus.req0_b;
          alsu_op_d = gnt ? bus.req1_op : bus.req0_op;
          rsp_id_d  = gnt;
          ptr_d     = !gnt;
          alsu_en_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        alsu_en_d = 1'b0;
        cnt_d     = CNT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = bus.alsu_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Returning to IDLE here means the next accept is one edge later.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      alsu_a_q    <= '0;
      alsu_b_q    <= '0;
      alsu_op_q   <= '0;
      alsu_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      alsu_a_q    <= alsu_a_d;
      alsu_b_q    <= alsu_b_d;
      alsu_op_q   <= alsu_op_d;
      alsu_en_q   <= alsu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.alsu_a      = alsu_a_q;
  assign bus.alsu_b      = alsu_b_q;
  assign bus.alsu_opcode = alsu_op_q;
  assign bus.alsu_en     = alsu_en_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alsu_ctrl.sv
//----------------------------------------------------------------------
// tb_alsu_ctrl -- bench for alsu_ctrl with an adder ALSU stub and a transaction model. rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_alsu_ctrl;
  localparam int WIDTH = 3;
  localparam int OPW   = 3;
  localparam int LAT   = 2;
  localparam int DW    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_ctrl_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alsu_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALSU stub: LAT-deep pipe of a+b; a non-loaded slot carries all-ones.
  logic [DW-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= bus.alsu_en ? (DW'(bus.alsu_a) + DW'(bus.alsu_b)) : '1;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.alsu_out = pipe[LAT-1];

  int n_chk  = 0;
  int n_pass = 0;

  // transaction model: one outstanding op, ages counted in visible cycles
  bit              m_busy = 0;
  int              m_acc  = 0;
  bit              m_id   = 0;
  bit              m_ptr  = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [OPW-1:0]  m_op   = '0;
  logic [DW-1:0]   m_res  = '0, m_held = '0;
  int              cyc    = 0;

  // observations for hand-computed checks
  int  gid_q[$], gstep_q[$], rd_q[$], rid_q[$];
  int  en_n, en_step, en_a, en_b, en_op, rise_step, hs_step;
  bit  prev_rv = 0;
  bit  busy_hist[int];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr_obs();
    gid_q.delete(); gstep_q.delete(); rd_q.delete(); rid_q.delete();
    en_n = 0; en_step = -1; en_a = -1; en_b = -1; en_op = -1;
    rise_step = -1; hs_step = -1;
  endtask

  task automatic step(input bit v0, input int a0, input int b0, input int o0,
                      input bit v1, input int a1, input int b1, input int o1,
                      input bit rr);
    int age;
    bit g, e_en, e_rv, e_r0, e_r1;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = WIDTH'(a0); bus.req0_b = WIDTH'(b0); bus.req0_op = OPW'(o0);
    bus.req1_valid = v1; bus.req1_a = WIDTH'(a1); bus.req1_b = WIDTH'(b1); bus.req1_op = OPW'(o1);
    bus.rsp_ready  = rr;
    #1;
    age  = cyc - m_acc;
    e_en = m_busy && (age == 0);
    e_rv = m_busy && (age >= LAT + 1);
    g    = (v0 && v1) ? m_ptr : v1;
    e_r0 = !m_busy && v0 && !g;
    e_r1 = !m_busy && v1 && g;
    chk("req0_ready", bus.req0_ready, e_r0);
    chk("req1_ready", bus.req1_ready, e_r1);
    chk("alsu_en", bus.alsu_en, e_en);
    chk("alsu_a", bus.alsu_a, m_a);
    chk("alsu_b", bus.alsu_b, m_b);
    chk("alsu_opcode", bus.alsu_opcode, m_op);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_id", bus.rsp_id, m_id);
    chk("rsp_data", bus.rsp_data, e_rv ? m_res : m_held);
    chk("busy", bus.busy, m_busy);

    busy_hist[cyc] = bus.busy;
    if (bus.alsu_en) begin
      en_n++; en_step = cyc; en_a = bus.alsu_a; en_b = bus.alsu_b; en_op = bus.alsu_opcode;
    end
    if (bus.rsp_valid && !prev_rv) rise_step = cyc;
    prev_rv = bus.rsp_valid;
    if (v0 && bus.req0_ready) begin gid_q.push_back(0); gstep_q.push_back(cyc); end
    if (v1 && bus.req1_ready) begin gid_q.push_back(1); gstep_q.push_back(cyc); end
    if (bus.rsp_valid && rr) begin
      rd_q.push_back(int'(bus.rsp_data)); rid_q.push_back(int'(bus.rsp_id)); hs_step = cyc;
    end

    if (!m_busy && (v0 || v1)) begin
      m_busy = 1; m_acc = cyc + 1; m_id = g; m_ptr = !g;
      m_a  = g ? WIDTH'(a1) : WIDTH'(a0);
      m_b  = g ? WIDTH'(b1) : WIDTH'(b0);
      m_op = g ? OPW'(o1)   : OPW'(o0);
      m_res = DW'(m_a) + DW'(m_b);
    end else if (e_rv && rr) begin
      m_busy = 0; m_held = m_res;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 0;
    clr_obs();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_alsu_en", bus.alsu_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst = 0;

    // single op from requester 0
    clr_obs();
    step(1, 3, 5, 1, 0, 0, 0, 0, 1);
    idle_steps(LAT + 5);
    chk("single_grant", qget(gid_q, 0), 0);
    chk("single_grant_count", gid_q.size(), 1);
    chk("single_en_cycles", en_n, 1);
    chk("single_en_after_accept", en_step - qget(gstep_q, 0), 1);
    chk("single_en_a", en_a, 3);
    chk("single_en_b", en_b, 5);
    chk("single_en_op", en_op, 1);
    chk("single_rsp_edges", rise_step - 1 - qget(gstep_q, 0), LAT + 1);
    chk("single_rsp_data", qget(rd_q, 0), 8);
    chk("single_rsp_id", qget(rid_q, 0), 0);
    chk("single_busy_after_hs", busy_hist.exists(hs_step + 1) ? int'(busy_hist[hs_step + 1]) : 1, 0);

    // asynchronous reset while waiting on the ALSU
    clr_obs();
    step(1, 5, 2, 6, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_alsu_a", bus.alsu_a, 0);
    chk("arst_alsu_b", bus.alsu_b, 0);
    chk("arst_alsu_opcode", bus.alsu_opcode, 0);
    chk("arst_alsu_en", bus.alsu_en, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_data", bus.rsp_data, 0);
    chk("arst_rsp_id", bus.rsp_id, 0);
    @(negedge clk);
    rst = 0;
    m_busy = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0; m_op = '0; m_held = '0; m_res = '0;
    prev_rv = 0;
    idle_steps(LAT + 4);

    // contention: grants alternate starting with requester 0
    clr_obs();
    for (int i = 0; i < 100 && gid_q.size() < 4; i++) step(1, 1, 1, 0, 1, 7, 7, 2, 1);
    for (int i = 0; i < 40 && rd_q.size() < 4; i++) idle_steps(1);
    for (int j = 0; j < 4; j++) begin
      chk("cont_grant", qget(gid_q, j), j % 2);
      chk("cont_data", qget(rd_q, j), (j % 2) ? 14 : 2);
      chk("cont_id", qget(rid_q, j), j % 2);
    end
    for (int j = 1; j < 4; j++)
      chk("cont_period", qget(gstep_q, j) - qget(gstep_q, j - 1), LAT + 3);

    // lone requester 1
    clr_obs();
    for (int i = 0; i < 100 && gid_q.size() < 3; i++) step(0, 0, 0, 0, 1, 4, 2, 5, 1);
    for (int i = 0; i < 40 && rd_q.size() < 3; i++) idle_steps(1);
    for (int j = 0; j < 3; j++) begin
      chk("lone_grant", qget(gid_q, j), 1);
      chk("lone_data", qget(rd_q, j), 6);
    end
    clr_obs();
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);
    chk("lone_ptr_end", qget(gid_q, 0), 0);
    idle_steps(LAT + 4);

    // backpressure on the response channel
    clr_obs();
    step(1, 2, 6, 3, 0, 0, 0, 0, 0);
    gid_q.delete(); gstep_q.delete();
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_rsp_seen", bus.rsp_valid, 1);
    repeat (5) step(1, 1, 2, 0, 1, 3, 4, 0, 0);
    chk("bp_no_hs_during_hold", rd_q.size(), 0);
    chk("bp_no_accept_during_hold", gid_q.size(), 0);
    step(1, 1, 2, 0, 1, 3, 4, 0, 1);
    step(1, 1, 2, 0, 1, 3, 4, 0, 1);
    chk("bp_data", qget(rd_q, 0), 8);
    chk("bp_next_accept", qget(gstep_q, 0) - hs_step, 1);
    idle_steps(LAT + 4);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
    idle_steps(LAT + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
